rect_motion_ctl: RTL and testbench
==================================

Name: rect_motion_ctl

Overview:
Parametrised per-frame vertical motion controller for a drawn rectangle, generalising the fixed gravity-fall rect controller. It models gravity, a damped floor bounce with a stop threshold, velocity saturation, and relaunch from the mouse button. Once per frame it feeds ypos to the draw_rect stage of top_vga, in the clk40 pixel-clock domain.

Parameters:
Y_W, 12, width of ypos and of all position constants
V_W, 12, width of the unsigned fixed-point velocity magnitude
FRAC, 4, fractional bits of velocity; pixels moved per frame = vel >> FRAC
GRAVITY, 3, velocity increment per frame, in 1/2^FRAC px/frame
V_MAX, 255, velocity saturation value
START_Y, 0, ypos in IDLE and after relaunch
Y_TOP, 0, minimum ypos; upward motion clamps here
FLOOR_Y, 536, ypos at floor contact
DAMP_SHIFT, 1, energy loss at bounce: vel_after = vel - (vel >> DAMP_SHIFT)
MIN_BOUNCE_V, 8, a bounce with vel_after below this value goes to REST

Ports:
clk  in  1  pixel clock (clk40 domain)
rst_n  in  1  asynchronous active-low reset
vs  in  1  vertical sync from the timing stage; its falling edge is the frame tick
m_left  in  1  left mouse button level, already synchronous to clk
ypos  out  Y_W  rectangle top y coordinate
vel  out  V_W  current velocity magnitude, fixed point
state  out  2  0=IDLE 1=FALL 2=RISE 3=REST
bounce_cnt  out  4  bounces since the last launch; saturates at 15

Behaviour:
- Reset (rst_n low, async): ypos=START_Y, vel=0, state=IDLE, bounce_cnt=0, vs_d=1, m_q=0. All outputs are registered.
- tick = vs_d & ~vs, with vs_d registered every clk. All state, position and velocity updates happen only in the tick cycle. New values are visible one clk after the tick cycle. Outputs hold between ticks.
- launch = m_left & ~m_q, evaluated at a tick. m_q samples m_left only at ticks, so a press is seen once per frame, however long it is held.
- IDLE: launch moves to FALL with ypos=START_Y, vel=0, bounce_cnt=0. There is no motion on the launch tick.
- FALL: vn = min(vel+GRAVITY, V_MAX); yn = ypos + (vn>>FRAC), computed at Y_W+1 bits.
  - If yn >= FLOOR_Y: ypos=FLOOR_Y, vd = vn - (vn>>DAMP_SHIFT), bounce_cnt increments (saturating).
    - vd < MIN_BOUNCE_V: vel=0, go to REST.
    - Otherwise: vel=vd, go to RISE.
  - Otherwise: ypos=yn, vel=vn.
- RISE:
  - If vel <= GRAVITY: vel=0, go to FALL; ypos unchanged.
  - Otherwise: vel = vel-GRAVITY; ypos = max(ypos - (vel_new>>FRAC), Y_TOP), using signed Y_W+1 arithmetic. Reaching Y_TOP does not change state.
- REST: ypos=FLOOR_Y, vel=0. Launch restarts directly into FALL with ypos=START_Y, vel=0, bounce_cnt=0.
- Launch during FALL or RISE restarts the same way (ypos=START_Y, vel=0, bounce_cnt=0, state=FALL). Launch has priority over physics on that tick.
- START_Y >= FLOOR_Y is a legal configuration: the first FALL tick is treated as floor contact.
- A tick and an m_left edge in the same clk are both honoured. Edge detection uses the pre-update m_q.
- Reset mid-motion returns to IDLE immediately, asynchronously. The first tick after reset release only primes vs_d and is not missed or duplicated.

Test Plan:
- Reset with m_left=1 held: all outputs at reset values. After release, the first tick launches (state=FALL, ypos=0, vel=0); later ticks do not relaunch while m_left stays high.
- Defaults, launch, then 10 ticks: vel=3k after tick k. ypos is 0 through tick 5, then 1,2,3,4,5 at ticks 6-10; vel=30. At tick 11, ypos=7 and vel=33.
- FLOOR_Y=5, launch, then 10 ticks: tick 10 gives ypos=5, vel=15, state=RISE, bounce_cnt=1. Tick 11 gives vel=12, ypos=5. Continue until vel<=3, then state returns to FALL with vel=0.
- FLOOR_Y=5, MIN_BOUNCE_V=16: tick 10 gives vel=0, state=REST, ypos=5. Further ticks with no launch leave it unchanged. A launch press then gives state=FALL, ypos=0, bounce_cnt=0.
- V_MAX=20, FLOOR_Y=4000: vel saturates at 20 from tick 7 onward. ypos then advances exactly 1 per tick.
- Pulse rst_n low between ticks while in RISE: ypos=START_Y, state=IDLE immediately. Two vs falling edges less than one frame apart each produce exactly one update.

Source files
------------

// File: rtl/rect_motion_ctl.sv
// Per-frame vertical motion for a drawn rectangle: gravity, damped floor
// bounce with stop threshold, velocity saturation and mouse relaunch.
module rect_motion_ctl #(
    parameter int Y_W          = 12,
    parameter int V_W          = 12,
    parameter int FRAC         = 4,
    parameter int GRAVITY      = 3,
    parameter int V_MAX        = 255,
    parameter int START_Y      = 0,
    parameter int Y_TOP        = 0,
    parameter int FLOOR_Y      = 536,
    parameter int DAMP_SHIFT   = 1,
    parameter int MIN_BOUNCE_V = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vs,
    input  logic           m_left,
    output logic [Y_W-1:0] ypos,
    output logic [V_W-1:0] vel,
    output logic [1:0]     state,
    output logic [3:0]     bounce_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FALL = 2'd1,
        S_RISE = 2'd2,
        S_REST = 2'd3
    } state_t;

    localparam logic [V_W:0]        LP_GRAV  = (V_W+1)'(GRAVITY);
    localparam logic [V_W:0]        LP_VMAX  = (V_W+1)'(V_MAX);
    localparam logic [V_W-1:0]      LP_MINB  = V_W'(MIN_BOUNCE_V);
    localparam logic [Y_W:0]        LP_FLOOR = (Y_W+1)'(FLOOR_Y);
    localparam logic [Y_W-1:0]      LP_START = Y_W'(START_Y);
    localparam logic signed [Y_W:0] LP_TOP   = (Y_W+1)'(Y_TOP);

    state_t         r_state;
    logic [Y_W-1:0] r_ypos;
    logic [V_W-1:0] r_vel;
    logic [3:0]     r_bcnt;
    logic           r_vs_d;
    logic           r_m_q;

    logic                  w_tick;
    logic                  w_launch;
    logic [V_W:0]          w_vsum;
    logic [V_W-1:0]        w_vn;
    logic [Y_W:0]          w_yn;
    logic [V_W-1:0]        w_vd;
    logic [V_W-1:0]        w_vr;
    logic                  w_rise_stop;
    logic signed [Y_W:0]   w_yr;
    logic [3:0]            w_bc_inc;

    assign w_tick   = r_vs_d & ~vs;
    assign w_launch = m_left & ~r_m_q;

    // Fall path: saturated velocity, then position step in Y_W+1 bits
    assign w_vsum = {1'b0, r_vel} + LP_GRAV;
    assign w_vn   = (w_vsum > LP_VMAX) ? LP_VMAX[V_W-1:0] : w_vsum[V_W-1:0];
    assign w_yn   = {1'b0, r_ypos} + (Y_W+1)'(w_vn >> FRAC);
    assign w_vd   = w_vn - (w_vn >> DAMP_SHIFT);

    assign w_rise_stop = ({1'b0, r_vel} <= LP_GRAV);
    assign w_vr        = r_vel - LP_GRAV[V_W-1:0];
    assign w_yr        = $signed({1'b0, r_ypos})
                       - $signed((Y_W+1)'(w_vr >> FRAC));

    assign w_bc_inc = (r_bcnt == 4'hF) ? 4'hF : r_bcnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ypos  <= LP_START;
            r_vel   <= '0;
            r_bcnt  <= '0;
            r_vs_d  <= 1'b1;
            r_m_q   <= 1'b0;
        end else begin
            r_vs_d <= vs;
            if (w_tick) begin
                r_m_q <= m_left;
                if (w_launch) begin
                    r_state <= S_FALL;
                    r_ypos  <= LP_START;
                    r_vel   <= '0;
                    r_bcnt  <= '0;
                end else begin
                    unique case (r_state)
                        S_IDLE: begin
                            r_state <= S_IDLE;
                        end
                        S_FALL: begin
                            if (w_yn >= LP_FLOOR) begin
                                r_ypos <= LP_FLOOR[Y_W-1:0];
                                r_bcnt <= w_bc_inc;
                                if (w_vd < LP_MINB) begin
                                    r_vel   <= '0;
                                    r_state <= S_REST;
                                end else begin
                                    r_vel   <= w_vd;
                                    r_state <= S_RISE;
                                end
                            end else begin
                                r_ypos <= w_yn[Y_W-1:0];
                                r_vel  <= w_vn;
                            end
                        end
                        S_RISE: begin
                            if (w_rise_stop) begin
                                r_vel   <= '0;
                                r_state <= S_FALL;
                            end else begin
                                r_vel  <= w_vr;
                                r_ypos <= (w_yr < LP_TOP) ? LP_TOP[Y_W-1:0]
                                                          : w_yr[Y_W-1:0];
                            end
                        end
                        S_REST: begin
                            r_ypos <= LP_FLOOR[Y_W-1:0];
                            r_vel  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign ypos       = r_ypos;
    assign vel        = r_vel;
    assign state      = r_state;
    assign bounce_cnt = r_bcnt;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Directed bench for rect_motion_ctl: four parameterisations share one
// stimulus stream; each scenario task checks the instance it targets.
module tb_rect_motion_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    logic m_left = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [11:0] y0, y1, y2, y3;
    logic [11:0] v0, v1, v2, v3;
    logic [1:0]  s0, s1, s2, s3;
    logic [3:0]  b0, b1, b2, b3;

    always #5 clk = ~clk;

    rect_motion_ctl u0 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .m_left(m_left),
        .ypos(y0), .vel(v0), .state(s0), .bounce_cnt(b0)
    );

    rect_motion_ctl #(.FLOOR_Y(5)) u1 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .m_left(m_left),
        .ypos(y1), .vel(v1), .state(s1), .bounce_cnt(b1)
    );

    rect_motion_ctl #(.FLOOR_Y(5), .MIN_BOUNCE_V(16)) u2 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .m_left(m_left),
        .ypos(y2), .vel(v2), .state(s2), .bounce_cnt(b2)
    );

    rect_motion_ctl #(.V_MAX(20), .FLOOR_Y(4000)) u3 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .m_left(m_left),
        .ypos(y3), .vel(v3), .state(s3), .bounce_cnt(b3)
    );

    task automatic tick();
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vs = 1'b1;
        m_left = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic launch();
        m_left = 1'b1;
        tick();
        m_left = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        m_left = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y0, v0, s0, b0} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outs got y=%0d v=%0d s=%0d b=%0d exp 0 0 0 0",
                     y0, v0, s0, b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick();
        checks++;
        if (s0 !== 2'd1 || y0 !== 12'd0 || v0 !== 12'd0) begin
            errors++;
            $display("FAIL reset_launch got s=%0d y=%0d v=%0d exp 1 0 0",
                     s0, y0, v0);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (s0 !== 2'd1 || v0 !== 12'(3 * k)) begin
                errors++;
                $display("FAIL held_no_relaunch t%0d got s=%0d v=%0d exp 1 %0d",
                         k, s0, v0, 3 * k);
            end
        end
        m_left = 1'b0;
    endtask

    task automatic test_gravity();
        int ey[11] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 7};
        do_reset();
        launch();
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (v0 !== 12'(3 * k) || y0 !== 12'(ey[k-1])) begin
                errors++;
                $display("FAIL gravity t%0d got v=%0d y=%0d exp %0d %0d",
                         k, v0, y0, 3 * k, ey[k-1]);
            end
        end
    endtask

    task automatic test_bounce();
        int ev[4] = '{12, 9, 6, 3};
        do_reset();
        launch();
        repeat (10) tick();
        checks++;
        if (y1 !== 12'd5 || v1 !== 12'd15 || s1 !== 2'd2 || b1 !== 4'd1) begin
            errors++;
            $display("FAIL bounce_hit got y=%0d v=%0d s=%0d b=%0d exp 5 15 2 1",
                     y1, v1, s1, b1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (v1 !== 12'(ev[k]) || y1 !== 12'd5 || s1 !== 2'd2) begin
                errors++;
                $display("FAIL rise t%0d got v=%0d y=%0d s=%0d exp %0d 5 2",
                         k, v1, y1, s1, ev[k]);
            end
        end
        tick();
        checks++;
        if (v1 !== 12'd0 || y1 !== 12'd5 || s1 !== 2'd1) begin
            errors++;
            $display("FAIL rise_apex got v=%0d y=%0d s=%0d exp 0 5 1",
                     v1, y1, s1);
        end
        tick();
        checks++;
        if (v1 !== 12'd0 || s1 !== 2'd3 || b1 !== 4'd2) begin
            errors++;
            $display("FAIL second_bounce got v=%0d s=%0d b=%0d exp 0 3 2",
                     v1, s1, b1);
        end
    endtask

    task automatic test_rest();
        do_reset();
        launch();
        repeat (10) tick();
        checks++;
        if (s2 !== 2'd3 || v2 !== 12'd0 || y2 !== 12'd5 || b2 !== 4'd1) begin
            errors++;
            $display("FAIL rest_enter got s=%0d v=%0d y=%0d b=%0d exp 3 0 5 1",
                     s2, v2, y2, b2);
        end
        repeat (3) tick();
        checks++;
        if (s2 !== 2'd3 || v2 !== 12'd0 || y2 !== 12'd5) begin
            errors++;
            $display("FAIL rest_hold got s=%0d v=%0d y=%0d exp 3 0 5",
                     s2, v2, y2);
        end
        launch();
        checks++;
        if (s2 !== 2'd1 || y2 !== 12'd0 || b2 !== 4'd0 || v2 !== 12'd0) begin
            errors++;
            $display("FAIL rest_launch got s=%0d y=%0d b=%0d v=%0d exp 1 0 0 0",
                     s2, y2, b2, v2);
        end
    endtask

    task automatic test_saturation();
        int ev;
        int eyp;
        do_reset();
        launch();
        for (int k = 1; k <= 12; k++) begin
            tick();
            ev  = (3 * k > 20) ? 20 : 3 * k;
            eyp = (k <= 5) ? 0 : k - 5;
            checks++;
            if (v3 !== 12'(ev) || y3 !== 12'(eyp)) begin
                errors++;
                $display("FAIL sat t%0d got v=%0d y=%0d exp %0d %0d",
                         k, v3, y3, ev, eyp);
            end
        end
    endtask

    task automatic test_relaunch();
        do_reset();
        launch();
        repeat (8) tick();
        checks++;
        if (y0 !== 12'd3 || v0 !== 12'd24) begin
            errors++;
            $display("FAIL pre_relaunch got y=%0d v=%0d exp 3 24", y0, v0);
        end
        launch();
        checks++;
        if (y0 !== 12'd0 || v0 !== 12'd0 || s0 !== 2'd1 || b0 !== 4'd0) begin
            errors++;
            $display("FAIL relaunch got y=%0d v=%0d s=%0d b=%0d exp 0 0 1 0",
                     y0, v0, s0, b0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        launch();
        repeat (11) tick();
        checks++;
        if (s1 !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_rise got s=%0d exp 2", s1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (y1 !== 12'd0 || s1 !== 2'd0 || v1 !== 12'd0 || b1 !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got y=%0d s=%0d v=%0d b=%0d exp 0 0 0 0",
                     y1, s1, v1, b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch();
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        checks++;
        if (v0 !== 12'd6 || s0 !== 2'd1) begin
            errors++;
            $display("FAIL close_ticks got v=%0d s=%0d exp 6 1", v0, s0);
        end
        vs = 1'b0;
        repeat (5) @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        checks++;
        if (v0 !== 12'd9) begin
            errors++;
            $display("FAIL long_vs_low got v=%0d exp 9", v0);
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_bounce();
        test_rest();
        test_saturation();
        test_relaunch();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
